// File: rtl/led_pkg.sv
// Shared definitions for the LED mode driver: mode codes, FSM states
// and the counter-width helper used to size every counter.
package led_pkg;

    // Command and current-mode encoding seen on the cmd_mode / cur_mode ports
    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_ON     = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_BREATH = 2'b11
    } mode_e;

    // Command handshake FSM: RUN accepts commands, PEND holds one until period end
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    // Width of a counter spanning 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_timebase.sv
// Time base for the LED driver: a 1 us prescaler and a PWM step counter.
// tick marks the last sys_clk cycle of each microsecond; period_end marks
// the last cycle of each full PWM period.
module led_timebase
    import led_pkg::*;
#(
    parameter int unsigned CLK_PER_US = 50,
    parameter int unsigned PWM_STEPS  = 1000,
    localparam int unsigned US_W      = cnt_width(CLK_PER_US),
    localparam int unsigned PWM_W     = cnt_width(PWM_STEPS)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    output logic             tick,
    output logic [PWM_W-1:0] pwm_cnt,
    output logic             period_end
);

    logic [US_W-1:0]  us_cnt_q;
    logic [US_W-1:0]  us_cnt_d;
    logic [PWM_W-1:0] pwm_cnt_q;
    logic [PWM_W-1:0] pwm_cnt_d;
    logic             us_last;
    logic             pwm_last;

    assign us_last    = (us_cnt_q == US_W'(CLK_PER_US - 1));
    assign pwm_last   = (pwm_cnt_q == PWM_W'(PWM_STEPS - 1));
    assign tick       = us_last;
    assign period_end = us_last && pwm_last;
    assign pwm_cnt    = pwm_cnt_q;

    // Next-state for both counters: prescaler wraps every us, PWM steps on tick
    always_comb begin
        us_cnt_d  = us_last ? '0 : us_cnt_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q;
        if (us_last) begin
            pwm_cnt_d = pwm_last ? '0 : pwm_cnt_q + 1'b1;
        end
    end

    // Counter registers, cleared asynchronously
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            us_cnt_q  <= '0;
            pwm_cnt_q <= '0;
        end else begin
            us_cnt_q  <= us_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

endmodule

// File: rtl/led_mode_driver.sv
// LED mode driver: accepts a mode command, applies it at the next PWM
// period boundary, and drives the LED as OFF, ON, BLINK or BREATH.
// The LED output is registered from the current mode/pattern state.
module led_mode_driver
    import led_pkg::*;
#(
    parameter int unsigned CLK_PER_US    = 50,
    parameter int unsigned PWM_STEPS     = 1000,
    parameter int unsigned BLINK_PERIODS = 500
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_mode,
    output logic       cmd_ready,
    output logic [1:0] cur_mode,
    output logic       led
);

    localparam int unsigned PWM_W = cnt_width(PWM_STEPS);
    localparam int unsigned BLK_W = cnt_width(BLINK_PERIODS);

    localparam logic [PWM_W-1:0] DUTY_MAX  = PWM_W'(PWM_STEPS - 1);
    localparam logic [BLK_W-1:0] BLINK_MAX = BLK_W'(BLINK_PERIODS - 1);

    // Time base outputs
    logic             tick_unused;
    logic [PWM_W-1:0] pwm_cnt;
    logic             period_end;

    // Handshake FSM state and registered outputs
    state_e state_q;
    mode_e  pend_mode_q;
    logic   cmd_ready_q;

    // Pattern state
    mode_e            cur_mode_q;
    mode_e            cur_mode_d;
    logic [PWM_W-1:0] duty_q;
    logic [PWM_W-1:0] duty_d;
    logic             dir_up_q;
    logic             dir_up_d;
    logic [BLK_W-1:0] blink_cnt_q;
    logic [BLK_W-1:0] blink_cnt_d;
    logic             phase_q;
    logic             phase_d;
    logic             led_q;
    logic             led_d;

    logic             load;

    // The driver only needs period_end; the raw tick is left unused here.
    led_timebase #(
        .CLK_PER_US (CLK_PER_US),
        .PWM_STEPS  (PWM_STEPS)
    ) u_timebase (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tick       (tick_unused),
        .pwm_cnt    (pwm_cnt),
        .period_end (period_end)
    );

    // A pending command takes effect on the period boundary that ends PEND
    assign load = (state_q == ST_PEND) && period_end;

    assign cmd_ready = cmd_ready_q;
    assign cur_mode  = cur_mode_q;
    assign led       = led_q;

    // Command handshake: latch the mode in RUN, wait for period end in PEND
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_RUN;
            pend_mode_q <= MODE_OFF;
            cmd_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cmd_valid) begin
                        pend_mode_q <= mode_e'(cmd_mode);
                        state_q     <= ST_PEND;
                        cmd_ready_q <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (period_end) begin
                        state_q     <= ST_RUN;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_RUN;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Pattern next-state: a load restarts the pattern (even for the same mode),
    // otherwise BLINK and BREATH advance once per PWM period
    always_comb begin
        cur_mode_d  = cur_mode_q;
        duty_d      = duty_q;
        dir_up_d    = dir_up_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (load) begin
            cur_mode_d  = pend_mode_q;
            duty_d      = '0;
            dir_up_d    = 1'b1;
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (period_end) begin
            case (cur_mode_q)
                MODE_BLINK: begin
                    if (blink_cnt_q == BLINK_MAX) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                MODE_BREATH: begin
                    // Reaching an endpoint flips direction without moving duty,
                    // so each endpoint is shown for exactly one extra period
                    if (dir_up_q) begin
                        if (duty_q == DUTY_MAX) begin
                            dir_up_d = 1'b0;
                        end else begin
                            duty_d = duty_q + 1'b1;
                        end
                    end else begin
                        if (duty_q == '0) begin
                            dir_up_d = 1'b1;
                        end else begin
                            duty_d = duty_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // LED value derived from the current mode and pattern state
    always_comb begin
        led_d = 1'b0;
        case (cur_mode_q)
            MODE_OFF:    led_d = 1'b0;
            MODE_ON:     led_d = 1'b1;
            MODE_BLINK:  led_d = phase_q;
            MODE_BREATH: led_d = (pwm_cnt < duty_q);
            default:     led_d = 1'b0;
        endcase
    end

    // Pattern and LED registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cur_mode_q  <= MODE_OFF;
            duty_q      <= '0;
            dir_up_q    <= 1'b1;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            led_q       <= 1'b0;
        end else begin
            cur_mode_q  <= cur_mode_d;
            duty_q      <= duty_d;
            dir_up_q    <= dir_up_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
        end
    end

endmodule

// File: tb/tb_led_mode_driver.sv
// Directed scoreboard bench for led_mode_driver with a short time base
// (2 clocks per tick, 4 ticks per PWM period, 2 periods per blink half).
module tb_led_mode_driver;

    localparam int unsigned CPU = 2;
    localparam int unsigned PS  = 4;
    localparam int unsigned BP  = 2;
    localparam int          PER = CPU * PS;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_mode  = 2'b00;
    logic       cmd_ready;
    logic [1:0] cur_mode;
    logic       led;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    led_mode_driver #(
        .CLK_PER_US    (CPU),
        .PWM_STEPS     (PS),
        .BLINK_PERIODS (BP)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_mode  (cmd_mode),
        .cmd_ready (cmd_ready),
        .cur_mode  (cur_mode),
        .led       (led)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] vec(input logic r, input logic [1:0] m, input logic l);
        return 32'({r, m, l});
    endfunction

    function automatic logic [31:0] obs_vec();
        return 32'({cmd_ready, cur_mode, led});
    endfunction

    // First cycle k > a on which period_end fires (cycle 0 = first after reset release)
    function automatic int next_pe(input int a);
        int k;
        k = a + 1;
        while ((k % PER) != PER - 1) k++;
        return k;
    endfunction

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=%0d at cycle %0d", obs, cyc);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s observed=%0d expected=%0d at cycle %0d", e.tag, obs, e.val, cyc);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) next_cycle();
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 4 * PER) begin
            next_cycle();
            n++;
        end
    endtask

    initial begin
        int a;
        int p;
        int p2;
        int cnt;
        int n;
        int breath_cnt[10] = '{0, 2, 4, 6, 6, 4, 2, 0, 0, 2};

        // Reset and idle: OFF, ready, LED dark for 100 cycles
        apply_reset();
        push("reset_state", vec(1'b1, 2'b00, 1'b0));
        compare(obs_vec());
        for (int i = 1; i <= 100; i++) push("idle", vec(1'b1, 2'b00, 1'b0));
        for (int i = 1; i <= 100; i++) begin
            next_cycle();
            compare(obs_vec());
        end

        // ON accepted at cycle 3: PEND until period_end at 7, mode at 8, LED at 9
        apply_reset();
        for (int k = 0; k <= 12; k++) begin
            if (k <= 3)      push("on_accept", vec(1'b1, 2'b00, 1'b0));
            else if (k <= 7) push("on_accept", vec(1'b0, 2'b00, 1'b0));
            else if (k == 8) push("on_accept", vec(1'b1, 2'b01, 1'b0));
            else             push("on_accept", vec(1'b1, 2'b01, 1'b1));
        end
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) next_cycle();
            compare(obs_vec());
            if (k == 3) begin
                cmd_valid = 1'b1;
                cmd_mode  = 2'b01;
            end
            if (k == 4) cmd_valid = 1'b0;
        end

        // BLINK: 16 cycles lit, 16 dark, repeating
        wait_ready();
        a = cyc;
        p = next_pe(a);
        cmd_valid = 1'b1;
        cmd_mode  = 2'b10;
        push("blink_mode", 32'(2'b10));
        for (int i = 0; i < 48; i++) push("blink_led", 32'(((i / 16) % 2) == 0));
        next_cycle();
        cmd_valid = 1'b0;
        run_to(p + 1);
        compare(32'(cur_mode));
        for (int i = 0; i < 48; i++) begin
            next_cycle();
            compare(32'(led));
        end

        // BREATH: lit cycles per period follow the triangle with held endpoints
        wait_ready();
        a = cyc;
        p = next_pe(a);
        cmd_valid = 1'b1;
        cmd_mode  = 2'b11;
        for (int w = 0; w < 10; w++) push("breath_lit", 32'(breath_cnt[w]));
        next_cycle();
        cmd_valid = 1'b0;
        run_to(p + 2);
        for (int w = 0; w < 10; w++) begin
            cnt = 0;
            for (int j = 0; j < PER; j++) begin
                cnt = cnt + (led ? 1 : 0);
                next_cycle();
            end
            compare(32'(cnt));
        end

        // Back-to-back commands: BLINK taken, BREATH ignored until ready returns
        wait_ready();
        a = cyc;
        p = next_pe(a);
        push("dbl_ready_rise", 32'(p + 1));
        push("dbl_first_mode", 32'(2'b10));
        push("dbl_second_busy", 32'(0));
        cmd_valid = 1'b1;
        cmd_mode  = 2'b10;
        next_cycle();
        cmd_mode  = 2'b11;
        next_cycle();
        cmd_valid = 1'b0;
        n = 0;
        while (!cmd_ready && n < 4 * PER) begin
            next_cycle();
            n++;
        end
        compare(32'(cyc));
        compare(32'(cur_mode));
        a = cyc;
        p2 = next_pe(a);
        cmd_valid = 1'b1;
        cmd_mode  = 2'b11;
        next_cycle();
        cmd_valid = 1'b0;
        compare(32'(cmd_ready));
        push("dbl_second_mode", 32'(2'b11));
        run_to(p2 + 1);
        compare(32'(cur_mode));

        // Reset while a BREATH command is pending: command is lost
        wait_ready();
        push("pend_busy", 32'(0));
        push("rst_async", vec(1'b1, 2'b00, 1'b0));
        for (int k = 0; k < 3 * PER; k++) push("rst_discard", vec(1'b1, 2'b00, 1'b0));
        cmd_valid = 1'b1;
        cmd_mode  = 2'b11;
        next_cycle();
        cmd_valid = 1'b0;
        compare(32'(cmd_ready));
        #2;
        sys_rst_n = 1'b0;
        #1;
        compare(obs_vec());
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 3 * PER; k++) begin
            if (k > 0) next_cycle();
            compare(obs_vec());
        end

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_mode_driver.md
LED_MODE_DRIVER -- requirements
Module: led_mode_driver

Interface
REQ-001 Parameter CLK_PER_US, default 50, sets the number of sys_clk cycles per 1 us tick.
REQ-002 Parameter PWM_STEPS, default 1000, sets the number of ticks per PWM period and the duty resolution.
REQ-003 Parameter BLINK_PERIODS, default 500, sets the number of PWM periods per blink half-cycle.
REQ-004 Port sys_clk, input, 1, system clock.
REQ-005 Port sys_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 Port cmd_valid, input, 1, mode command present.
REQ-007 Port cmd_mode, input, 2, requested mode: 00 OFF, 01 ON, 10 BLINK, 11 BREATH.
REQ-008 Port cmd_ready, output, 1, driver can accept a command.
REQ-009 Port cur_mode, output, 2, mode currently driving the LED.
REQ-010 Port led, output, 1, LED drive, registered, 1 = lit.

Function
REQ-011 Counter us_cnt SHALL count 0..CLK_PER_US-1 and wrap; tick SHALL be asserted when us_cnt == CLK_PER_US-1.
REQ-012 Counter pwm_cnt SHALL advance on tick over 0..PWM_STEPS-1 and wrap; period_end = tick && pwm_cnt == PWM_STEPS-1.
REQ-013 A command SHALL be accepted on a cycle with cmd_valid && cmd_ready; cmd_mode SHALL be latched into pend_mode.
REQ-014 FSM states: RUN (cmd_ready=1) and PEND (cmd_ready=0); accept moves RUN->PEND; period_end in PEND moves to RUN.
REQ-015 On period_end in PEND, cur_mode SHALL take pend_mode, and duty=0, dir=up, blink_cnt=0, and phase=1 SHALL be loaded in the same cycle.
REQ-016 cmd_valid SHALL be ignored in PEND; the second of two back-to-back commands SHALL wait until cmd_ready returns.
REQ-017 Accepting a command equal to cur_mode SHALL still restart that mode's pattern at the next period_end.
REQ-018 OFF: led = 0; ON: led = 1.
REQ-019 BLINK: blink_cnt SHALL count period_end events over 0..BLINK_PERIODS-1; phase SHALL toggle on wrap; led = phase.
REQ-020 BREATH: led = (pwm_cnt < duty).
REQ-021 BREATH duty SHALL update on period_end: up increments to PWM_STEPS-1, then dir flips to down; down decrements to 0, then dir flips to up.
REQ-022 Duty endpoints SHALL each be held for exactly one period, with no overflow or underflow.
REQ-023 led SHALL be registered one cycle after the counter and state values that determine it.
REQ-024 Counter widths SHALL be $clog2 of the respective parameter, minimum 1 bit.

Reset
REQ-025 On sys_rst_n low, all counters SHALL be 0, the FSM SHALL be RUN, cur_mode = OFF, pend_mode = OFF, duty = 0, dir = up, phase = 1, led = 0, and cmd_ready = 1.
REQ-026 Reset asserted mid-PEND SHALL discard the pending command.
REQ-027 On the first cycle after release, counting SHALL begin and cmd_ready SHALL be 1.

Structure
REQ-028 Package led_pkg SHALL hold the 2-bit mode constants (MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATH) and the FSM state encodings.
REQ-029 Sub-module led_timebase SHALL own us_cnt and pwm_cnt and output tick, pwm_cnt, and period_end.
REQ-030 All other logic SHALL reside in led_mode_driver.

Verification (CLK_PER_US=2, PWM_STEPS=4, BLINK_PERIODS=2)
REQ-031 Reset release, no command -> led = 0, cur_mode = 00, and cmd_ready = 1 for 100 cycles.
REQ-032 cmd_mode = 01 accepted at cycle 3 -> cmd_ready = 0 until period_end at cycle 7; cur_mode = 01 at cycle 8; led = 1 at cycle 9.
REQ-033 BLINK selected -> led SHALL be 1 for 16 cycles, then 0 for 16 cycles, repeating.
REQ-034 BREATH selected -> lit cycles per 8-cycle period SHALL follow 0, 2, 4, 6, 6, 4, 2, 0, 0, 2, ...
REQ-035 cmd_valid held for 2 cycles with modes 10 then 11 -> only 10 is accepted; 11 is accepted after cmd_ready rises.
REQ-036 Reset pulsed while in PEND with mode 11 -> cur_mode = 00 and led = 0 after release; the pending command is lost.
